// File: rtl/iommu_w_translate.sv
// iommu_w_translate: AXI4 write-path IOVA->PA translation stage with W-beat buffering and fault drain
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bypass             bare mode (no walker), sampled with the accepted AW
//   s_axi_aw*/w*/b*    upstream AXI4 write slave (IOVA side)
//   m_axi_aw*/w*/b*    downstream AXI4 write master (physical side)
//   tr_req_*           page walk request (VPN)
//   tr_resp_*          page walk response (PPN or fault)
//   fault_irq          one-cycle pulse per faulted burst
//   fault_count        saturating count of faulted bursts
module iommu_w_translate #(
   parameter int SADDR_W    = 64,
   parameter int MADDR_W    = 34,
   parameter int DATA_W     = 256,
   parameter int ID_W       = 3,
   parameter int WBUF_DEPTH = 16,
   parameter int PAGE_SHIFT = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bypass,
   input  logic [SADDR_W-1:0]         s_axi_awaddr,
   input  logic [7:0]                 s_axi_awlen,
   input  logic [2:0]                 s_axi_awsize,
   input  logic [1:0]                 s_axi_awburst,
   input  logic                       s_axi_awlock,
   input  logic [3:0]                 s_axi_awcache,
   input  logic [2:0]                 s_axi_awprot,
   input  logic [ID_W-1:0]            s_axi_awid,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [DATA_W-1:0]          s_axi_wdata,
   input  logic [DATA_W/8-1:0]        s_axi_wstrb,
   input  logic                       s_axi_wlast,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic [ID_W-1:0]            s_axi_bid,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   output logic [MADDR_W-1:0]         m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awlock,
   output logic [3:0]                 m_axi_awcache,
   output logic [2:0]                 m_axi_awprot,
   output logic [ID_W-1:0]            m_axi_awid,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [DATA_W-1:0]          m_axi_wdata,
   output logic [DATA_W/8-1:0]        m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic [1:0]                 m_axi_bresp,
   input  logic [ID_W-1:0]            m_axi_bid,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,
   output logic [SADDR_W-PAGE_SHIFT-1:0] tr_req_vpn,
   output logic                       tr_req_valid,
   input  logic                       tr_req_ready,
   input  logic [MADDR_W-PAGE_SHIFT-1:0] tr_resp_ppn,
   input  logic                       tr_resp_fault,
   input  logic                       tr_resp_valid,
   output logic                       fault_irq,
   output logic [15:0]                fault_count
);
   typedef enum logic [3:0] {IDLE, CHECK, XREQ, XWAIT, AW, WFWD, BWAIT, DRAIN, BERR} state_t;
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int BW = DATA_W + DATA_W/8 + 1;
   localparam int unsigned DEPTH = WBUF_DEPTH;
   localparam logic [PW:0] FULL = DEPTH[PW:0];
   localparam logic [SADDR_W:0] ONE = 1;
   state_t state_q, state_d;
   logic [SADDR_W-1:0] addr_q;
   logic [7:0] len_q;
   logic [2:0] size_q, prot_q;
   logic [1:0] burst_q;
   logic lock_q, byp_q, irq_q;
   logic [3:0] cache_q;
   logic [ID_W-1:0] id_q;
   logic [MADDR_W-1:0] phys_q;
   logic [15:0] fcnt_q;
   logic [BW-1:0] mem [WBUF_DEPTH];
   logic [PW-1:0] wp_q, rp_q;
   logic [PW:0] cnt_q;
   logic [BW-1:0] head;
   logic empty, full, push, pop, range_f, enter_drain;
   logic [SADDR_W:0] beats, last_a;
   assign empty = cnt_q == '0;
   assign full  = cnt_q == FULL;
   assign head  = mem[rp_q];
   assign push  = s_axi_wvalid & s_axi_wready;
   // Last byte of the burst, one bit wider than the IOVA so wrap past the top is seen as a crossing
   assign beats  = {{(SADDR_W-7){1'b0}}, len_q} + ONE;
   assign last_a = {1'b0, addr_q} + (beats << size_q) - ONE;
   assign range_f = (burst_q == 2'b01 && last_a[SADDR_W:PAGE_SHIFT] != {1'b0, addr_q[SADDR_W-1:PAGE_SHIFT]})
                  || (byp_q && |addr_q[SADDR_W-1:MADDR_W]);
   always_comb begin
      state_d = state_q;
      pop = 1'b0;
      case (state_q)
         IDLE:  if (s_axi_awvalid) state_d = CHECK;
         CHECK: state_d = range_f ? DRAIN : byp_q ? AW : XREQ;
         XREQ:  if (tr_req_ready) state_d = XWAIT;
         XWAIT: if (tr_resp_valid) state_d = tr_resp_fault ? DRAIN : AW;
         AW:    if (m_axi_awready) state_d = WFWD;
         WFWD: begin
            pop = m_axi_wready & ~empty;
            if (pop && head[0]) state_d = BWAIT;
         end
         BWAIT: if (m_axi_bvalid && s_axi_bready) state_d = IDLE;
         DRAIN: begin
            pop = ~empty;
            if (pop && head[0]) state_d = BERR;
         end
         BERR:  if (s_axi_bready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign enter_drain = state_d == DRAIN && state_q != DRAIN;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         fcnt_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         irq_q   <= enter_drain;
         fcnt_q  <= fcnt_q + 16'(enter_drain & ~&fcnt_q);
         wp_q    <= wp_q + PW'(push);
         rp_q    <= rp_q + PW'(pop);
         cnt_q   <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (state_q == IDLE && s_axi_awvalid) begin
         addr_q  <= s_axi_awaddr;
         len_q   <= s_axi_awlen;
         size_q  <= s_axi_awsize;
         burst_q <= s_axi_awburst;
         lock_q  <= s_axi_awlock;
         cache_q <= s_axi_awcache;
         prot_q  <= s_axi_awprot;
         id_q    <= s_axi_awid;
         byp_q   <= bypass;
      end
      if (state_q == CHECK) phys_q <= addr_q[MADDR_W-1:0];
      else if (state_q == XWAIT && tr_resp_valid) phys_q <= {tr_resp_ppn, addr_q[PAGE_SHIFT-1:0]};
      if (push) mem[wp_q] <= {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
   end
   // Handshake outputs are held low while rst is asserted, whatever the state register holds
   assign s_axi_awready = ~rst && state_q == IDLE;
   assign s_axi_wready  = ~rst & ~full;
   assign tr_req_valid  = ~rst && state_q == XREQ;
   assign tr_req_vpn    = addr_q[SADDR_W-1:PAGE_SHIFT];
   assign m_axi_awvalid = ~rst && state_q == AW;
   assign m_axi_awaddr  = phys_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = size_q;
   assign m_axi_awburst = burst_q;
   assign m_axi_awlock  = lock_q;
   assign m_axi_awcache = cache_q;
   assign m_axi_awprot  = prot_q;
   assign m_axi_awid    = id_q;
   assign m_axi_wvalid  = ~rst && state_q == WFWD && ~empty;
   assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = head;
   assign m_axi_bready  = ~rst && state_q == BWAIT && s_axi_bready;
   assign s_axi_bvalid  = ~rst && ((state_q == BWAIT && m_axi_bvalid) || state_q == BERR);
   assign s_axi_bresp   = state_q == BERR ? 2'b10 : m_axi_bresp;
   assign s_axi_bid     = state_q == BERR ? id_q : m_axi_bid;
   assign fault_irq     = irq_q;
   assign fault_count   = fcnt_q;
endmodule
